// File: rtl/gato_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gato_pkg : shared cell codes, game-state codes and winning lines     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package gato_pkg;

  localparam int CELDAS     = 9;
  localparam int NUM_LINEAS = 8;

  localparam logic [1:0] VACIA   = 2'b00;
  localparam logic [1:0] MARCA_X = 2'b01;
  localparam logic [1:0] MARCA_O = 2'b10;

  localparam logic [1:0] EN_JUEGO = 2'b00;
  localparam logic [1:0] GANA_X   = 2'b01;
  localparam logic [1:0] GANA_O   = 2'b10;
  localparam logic [1:0] EMPATE   = 2'b11;

  typedef logic [3:0]     celda_t;
  typedef celda_t [2:0]   linea_t;

  // Rows, columns, diagonals as row-major cell-index triples
  localparam linea_t [NUM_LINEAS-1:0] LINEAS_GANADORAS = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  function automatic logic [1:0] marca_de_turno(input logic turno);
    return turno ? MARCA_O : MARCA_X;
  endfunction

endpackage
`default_nettype wire

// File: rtl/detector_ganador.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | detector_ganador : flags when the given mark fills any winning line  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module detector_ganador
  import gato_pkg::*;
(
  input  logic [2*CELDAS-1:0] i_tablero,
  input  logic [1:0]          i_marca,
  output logic                o_gana
);

  logic [NUM_LINEAS-1:0] w_linea;

  for (genvar l = 0; l < NUM_LINEAS; l++) begin : g_lineas
    localparam int C0 = int'(LINEAS_GANADORAS[l][0]);
    localparam int C1 = int'(LINEAS_GANADORAS[l][1]);
    localparam int C2 = int'(LINEAS_GANADORAS[l][2]);
    assign w_linea[l] = (i_tablero[2*C0 +: 2] == i_marca) &&
                        (i_tablero[2*C1 +: 2] == i_marca) &&
                        (i_tablero[2*C2 +: 2] == i_marca);
  end

  // An empty mark never counts as a line owner
  assign o_gana = (i_marca != VACIA) && (|w_linea);

endmodule
`default_nettype wire

// File: rtl/escritor_tablero.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | escritor_tablero : validates moves, writes the board, tracks result  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module escritor_tablero
  import gato_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                nuevo_juego,
  input  logic                jugada_valida,
  input  logic [3:0]          jugada_celda,
  output logic                jugada_lista,
  output logic                jugada_error,
  output logic [2*CELDAS-1:0] tablero,
  output logic                turno,
  output logic [1:0]          estado_juego,
  output logic [3:0]          num_jugadas
);

  localparam logic [1:0] ESPERA = 2'd0;
  localparam logic [1:0] EVALUA = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  logic [1:0]          r_estado;
  logic [1:0]          w_estado_sig;
  logic [2*CELDAS-1:0] r_tablero;
  logic                r_turno;
  logic                r_error;
  logic [1:0]          r_estado_juego;
  logic [3:0]          r_num;

  logic       w_lista;
  logic       w_acepta;
  logic       w_celda_vacia;
  logic       w_gana;
  logic       w_tablero_lleno;
  logic [1:0] w_marca;

  assign w_marca         = marca_de_turno(r_turno);
  assign w_acepta        = jugada_valida & w_lista;
  assign w_tablero_lleno = (r_num == 4'(CELDAS));

  // Indices 9..15 match no cell and therefore read as occupied
  always_comb begin
    w_celda_vacia = 1'b0;
    for (int i = 0; i < CELDAS; i++) begin
      if (jugada_celda == 4'(i)) w_celda_vacia = (r_tablero[2*i +: 2] == VACIA);
    end
  end

  detector_ganador u_detector (
    .i_tablero (r_tablero),
    .i_marca   (w_marca),
    .o_gana    (w_gana)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= ESPERA;
    else        r_estado <= w_estado_sig;
  end

  always_comb begin
    w_estado_sig = r_estado;
    if (nuevo_juego) begin
      w_estado_sig = ESPERA;
    end else begin
      case (r_estado)
        ESPERA:  if (w_acepta && w_celda_vacia) w_estado_sig = EVALUA;
        EVALUA:  w_estado_sig = (w_gana || w_tablero_lleno) ? FIN : ESPERA;
        FIN:     w_estado_sig = FIN;
        default: w_estado_sig = ESPERA;
      endcase
    end
  end

  always_comb begin
    w_lista = (r_estado == ESPERA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tablero      <= '0;
      r_turno        <= 1'b0;
      r_error        <= 1'b0;
      r_estado_juego <= EN_JUEGO;
      r_num          <= '0;
    end else if (nuevo_juego) begin
      r_tablero      <= '0;
      r_turno        <= 1'b0;
      r_error        <= 1'b0;
      r_estado_juego <= EN_JUEGO;
      r_num          <= '0;
    end else begin
      r_error <= 1'b0;
      case (r_estado)
        ESPERA: begin
          if (w_acepta) begin
            if (w_celda_vacia) begin
              for (int i = 0; i < CELDAS; i++) begin
                if (jugada_celda == 4'(i)) r_tablero[2*i +: 2] <= w_marca;
              end
              r_num <= r_num + 4'd1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        // Turn is still the mover's here, so only that player is tested
        EVALUA: begin
          if (w_gana)               r_estado_juego <= r_turno ? GANA_O : GANA_X;
          else if (w_tablero_lleno) r_estado_juego <= EMPATE;
          else                      r_turno        <= ~r_turno;
        end
        default: ;
      endcase
    end
  end

  assign jugada_lista = w_lista;
  assign jugada_error = r_error;
  assign tablero      = r_tablero;
  assign turno        = r_turno;
  assign estado_juego = r_estado_juego;
  assign num_jugadas  = r_num;

endmodule
`default_nettype wire

// File: tb/tb_escritor_tablero.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_escritor_tablero : scoreboard bench for the tic-tac-toe writer    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_escritor_tablero;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        nuevo_juego = 1'b0;
  logic        jugada_valida = 1'b0;
  logic [3:0]  jugada_celda = 4'd0;
  logic        jugada_lista;
  logic        jugada_error;
  logic [17:0] tablero;
  logic        turno;
  logic [1:0]  estado_juego;
  logic [3:0]  num_jugadas;

  always #5 clk = ~clk;

  escritor_tablero dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .nuevo_juego   (nuevo_juego),
    .jugada_valida (jugada_valida),
    .jugada_celda  (jugada_celda),
    .jugada_lista  (jugada_lista),
    .jugada_error  (jugada_error),
    .tablero       (tablero),
    .turno         (turno),
    .estado_juego  (estado_juego),
    .num_jugadas   (num_jugadas)
  );

  typedef struct packed {
    logic        err;
    logic [17:0] tab;
    logic        turno;
    logic [1:0]  est;
    logic [3:0]  num;
    logic        lista;
  } esperado_t;

  esperado_t sb[$];
  int checks   = 0;
  int failures = 0;

  logic [17:0] m_tab;
  logic        m_turno;
  logic [1:0]  m_est;
  logic [3:0]  m_num;
  logic        m_fin;

  function automatic bit linea_completa(input logic [17:0] t, input logic [1:0] m,
                                        input int a, input int b, input int c);
    return (t[2*a +: 2] == m) && (t[2*b +: 2] == m) && (t[2*c +: 2] == m);
  endfunction

  function automatic bit hay_ganador(input logic [17:0] t, input logic [1:0] m);
    bit g = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (linea_completa(t, m, 3*k, 3*k+1, 3*k+2)) g = 1'b1;
      if (linea_completa(t, m, k, k+3, k+6))       g = 1'b1;
    end
    if (linea_completa(t, m, 0, 4, 8) || linea_completa(t, m, 2, 4, 6)) g = 1'b1;
    return g;
  endfunction

  task automatic modelo_reset();
    m_tab = '0; m_turno = 1'b0; m_est = 2'b00; m_num = 4'd0; m_fin = 1'b0;
  endtask

  task automatic nuevo();
    @(negedge clk); nuevo_juego = 1'b1;
    @(posedge clk); #1; nuevo_juego = 1'b0;
    modelo_reset();
  endtask

  // One move: predict, push, drive, then pop and compare when the result is visible
  task automatic jugar(input logic [3:0] celda);
    esperado_t e;
    esperado_t o;
    bit        legal;
    logic [1:0] marca;
    legal = 1'b0;
    if (!m_fin && celda <= 4'd8) legal = (m_tab[2*celda +: 2] == 2'b00);
    e.err = !m_fin && !legal;
    if (legal) begin
      marca = m_turno ? 2'b10 : 2'b01;
      m_tab[2*celda +: 2] = marca;
      m_num = m_num + 4'd1;
      if (hay_ganador(m_tab, marca)) begin
        m_est = m_turno ? 2'b10 : 2'b01; m_fin = 1'b1;
      end else if (m_num == 4'd9) begin
        m_est = 2'b11; m_fin = 1'b1;
      end else begin
        m_turno = ~m_turno;
      end
    end
    e.tab = m_tab; e.turno = m_turno; e.est = m_est; e.num = m_num; e.lista = !m_fin;
    sb.push_back(e);

    @(negedge clk); jugada_valida = 1'b1; jugada_celda = celda;
    @(posedge clk); #1; jugada_valida = 1'b0;
    if (legal) begin
      checks++;
      if (jugada_lista !== 1'b0) begin
        failures++; $display("FAIL lista_ocupada celda=%0d got=%b want=0", celda, jugada_lista);
      end
      @(posedge clk); #1;
    end

    o = sb.pop_front();
    checks++;
    if (jugada_error !== o.err) begin
      failures++; $display("FAIL error celda=%0d got=%b want=%b", celda, jugada_error, o.err);
    end
    checks++;
    if (tablero !== o.tab) begin
      failures++; $display("FAIL tablero celda=%0d got=%h want=%h", celda, tablero, o.tab);
    end
    checks++;
    if (turno !== o.turno) begin
      failures++; $display("FAIL turno celda=%0d got=%b want=%b", celda, turno, o.turno);
    end
    checks++;
    if (estado_juego !== o.est) begin
      failures++; $display("FAIL estado celda=%0d got=%b want=%b", celda, estado_juego, o.est);
    end
    checks++;
    if (num_jugadas !== o.num) begin
      failures++; $display("FAIL num celda=%0d got=%0d want=%0d", celda, num_jugadas, o.num);
    end
    checks++;
    if (jugada_lista !== o.lista) begin
      failures++; $display("FAIL lista celda=%0d got=%b want=%b", celda, jugada_lista, o.lista);
    end
  endtask

  task automatic test_reset();
    modelo_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tablero, turno, estado_juego, num_jugadas, jugada_error, jugada_lista} !== {18'h0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset got tab=%h tu=%b est=%b num=%0d err=%b lista=%b want 0/0/00/0/0/1",
               tablero, turno, estado_juego, num_jugadas, jugada_error, jugada_lista);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basica();
    jugar(4'd4); jugar(4'd0); jugar(4'd8);
    checks++;
    if (tablero !== 18'h10102) begin
      failures++; $display("FAIL basica_tablero got=%h want=10102", tablero);
    end
    checks++;
    if ({turno, num_jugadas, estado_juego} !== {1'b1, 4'd3, 2'b00}) begin
      failures++; $display("FAIL basica_estado got tu=%b num=%0d est=%b want 1/3/00", turno, num_jugadas, estado_juego);
    end
  endtask

  task automatic test_ilegales();
    nuevo();
    jugar(4'd4); jugar(4'd4); jugar(4'd12);
    @(posedge clk); #1;
    checks++;
    if (jugada_error !== 1'b0) begin
      failures++; $display("FAIL error_un_ciclo got=%b want=0", jugada_error);
    end
    checks++;
    if ({tablero, turno, num_jugadas} !== {18'h00100, 1'b1, 4'd1}) begin
      failures++; $display("FAIL ilegales got tab=%h tu=%b num=%0d want 00100/1/1", tablero, turno, num_jugadas);
    end
  endtask

  task automatic test_victoria();
    nuevo();
    jugar(4'd0); jugar(4'd3); jugar(4'd1); jugar(4'd4); jugar(4'd2);
    checks++;
    if ({estado_juego, turno} !== {2'b01, 1'b0}) begin
      failures++; $display("FAIL victoria_x got est=%b tu=%b want 01/0", estado_juego, turno);
    end
    jugar(4'd5);
  endtask

  task automatic test_empate();
    nuevo();
    foreach (c_seq[i]) jugar(c_seq[i]);
    checks++;
    if ({estado_juego, num_jugadas} !== {2'b11, 4'd9}) begin
      failures++; $display("FAIL empate got est=%b num=%0d want 11/9", estado_juego, num_jugadas);
    end
  endtask

  task automatic test_victoria_noveno();
    nuevo();
    foreach (c_seq9[i]) jugar(c_seq9[i]);
    checks++;
    if ({estado_juego, num_jugadas} !== {2'b01, 4'd9}) begin
      failures++; $display("FAIL victoria_noveno got est=%b num=%0d want 01/9", estado_juego, num_jugadas);
    end
  endtask

  task automatic test_nuevo_juego();
    nuevo();
    jugar(4'd0); jugar(4'd4);
    @(negedge clk); nuevo_juego = 1'b1; jugada_valida = 1'b1; jugada_celda = 4'd2;
    @(posedge clk); #1; nuevo_juego = 1'b0; jugada_valida = 1'b0;
    modelo_reset();
    @(posedge clk); #1;
    checks++;
    if ({tablero, num_jugadas, turno, jugada_lista} !== {18'h0, 4'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL nuevo_con_jugada got tab=%h num=%0d tu=%b lista=%b want 0/0/0/1",
                           tablero, num_jugadas, turno, jugada_lista);
    end
  endtask

  task automatic test_reset_async();
    nuevo();
    @(negedge clk); jugada_valida = 1'b1; jugada_celda = 4'd4;
    @(posedge clk); #1; jugada_valida = 1'b0;
    checks++;
    if ({jugada_lista, tablero} !== {1'b0, 18'h00100}) begin
      failures++; $display("FAIL evalua_previo got lista=%b tab=%h want 0/00100", jugada_lista, tablero);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tablero, turno, estado_juego, num_jugadas, jugada_error, jugada_lista} !== {18'h0, 1'b0, 2'b00, 4'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_async got tab=%h tu=%b est=%b num=%0d err=%b lista=%b want 0/0/00/0/0/1",
               tablero, turno, estado_juego, num_jugadas, jugada_error, jugada_lista);
    end
    @(negedge clk); rst_n = 1'b1;
    modelo_reset();
    jugar(4'd4); jugar(4'd0);
  endtask

  logic [3:0] c_seq  [9] = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd3, 4'd5, 4'd7, 4'd6, 4'd8};
  logic [3:0] c_seq9 [9] = '{4'd1, 4'd0, 4'd3, 4'd2, 4'd5, 4'd6, 4'd7, 4'd8, 4'd4};

  initial begin
    test_reset();
    test_basica();
    test_ilegales();
    test_victoria();
    test_empate();
    test_victoria_noveno();
    test_nuevo_juego();
    test_reset_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
